// File: rtl/tdm_mux_if.sv
// ============================================================================
// Module      : tdm_mux_if
// Description : Channel/output bundle for the four-channel TDM multiplexer.
//               The slave modport is the multiplexer's view. The master
//               modport is the view of the environment that drives the
//               channels and consumes the output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tdm_mux_if #(
    parameter int DATA_W = 8
);
    // Channel words and their offer/take handshakes
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] C;
    logic [DATA_W-1:0] D;
    logic              a_valid;
    logic              b_valid;
    logic              c_valid;
    logic              d_valid;
    logic              a_ready;
    logic              b_ready;
    logic              c_ready;
    logic              d_ready;

    // Registered output word, its source channel and its handshake
    logic [DATA_W-1:0] data;
    logic [1:0]        sel;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  A, B, C, D,
        input  a_valid, b_valid, c_valid, d_valid,
        output a_ready, b_ready, c_ready, d_ready,
        output data, sel, out_valid,
        input  out_ready
    );

    modport master (
        output A, B, C, D,
        output a_valid, b_valid, c_valid, d_valid,
        input  a_ready, b_ready, c_ready, d_ready,
        input  data, sel, out_valid,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/tdm_mux.sv
// ============================================================================
// Module      : tdm_mux
// Description : Four-channel time-division multiplexer with a single
//               registered output word {out_valid, data, sel}.
//               Default build: strict TDM. The slot pointer advances on
//               every cycle in which the output register can load.
//               TDM_MUX_SKIP_IDLE_EN: work-conserving round robin. The
//               grant goes to the first valid channel at or after the
//               pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_mux #(
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    tdm_mux_if.slave       bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_out_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_sel;
    logic [1:0]        r_ptr;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_word [4];
    logic [3:0]        w_valid;
    logic [3:0]        w_ready;
    logic [1:0]        w_grant;
    logic              w_load_en;
    logic              w_xfer;

    assign w_word[0] = bus.A;
    assign w_word[1] = bus.B;
    assign w_word[2] = bus.C;
    assign w_word[3] = bus.D;
    assign w_valid   = {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};

    // The output register can take a new word when it is empty or being drained
    assign w_load_en = !r_out_valid || bus.out_ready;

`ifdef TDM_MUX_SKIP_IDLE_EN
    logic [1:0] w_idx;

    // Pick the first valid channel starting at the pointer. The loop scans
    // downwards, so the nearest candidate overwrites the farther ones.
    // With no valid channel the grant rests on the pointer slot.
    always_comb begin
        w_grant = r_ptr;
        w_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_valid[w_idx]) begin
                w_grant = w_idx;
            end
        end
    end
`else
    // Strict TDM: the slot owner is the pointer, whether or not it is valid
    always_comb begin
        w_grant = r_ptr;
    end
`endif

    assign w_xfer = w_load_en && w_valid[w_grant];

    // Exactly the granted channel sees ready. Ready is masked during reset so
    // that nothing upstream believes a word was consumed.
    always_comb begin
        w_ready = 4'b0000;
        if (!reset && w_load_en) begin
            w_ready = 4'b0001 << w_grant;
        end
    end

    assign bus.a_ready   = w_ready[0];
    assign bus.b_ready   = w_ready[1];
    assign bus.c_ready   = w_ready[2];
    assign bus.d_ready   = w_ready[3];
    assign bus.data      = r_data;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_out_valid;

    // Output register. Load on transfer, empty on an idle load slot, hold
    // under back-pressure. An empty slot keeps data/sel unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_sel       <= 2'b00;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_data      <= w_word[w_grant];
                r_sel       <= w_grant;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef TDM_MUX_SKIP_IDLE_EN
    // Round-robin pointer: resume just after the channel that was served.
    // It holds when nothing was taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 2'd0;
        end else if (w_xfer) begin
            r_ptr <= w_grant + 2'd1;
        end
    end
`else
    // Slot pointer: step one slot on every loadable cycle. Wraps 3 -> 0 naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 2'd0;
        end else if (w_load_en) begin
            r_ptr <= r_ptr + 2'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/tdm_mux.md
TDM_MUX -- requirements
Module: tdm_mux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of each channel word and of the output word.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports A, B, C, D, input, DATA_W bits each: channel 0..3 words.
REQ-005 The block SHALL have ports a_valid, b_valid, c_valid, d_valid, input, 1 bit each: the channel word is offered.
REQ-006 The block SHALL have ports a_ready, b_ready, c_ready, d_ready, output, 1 bit each: the channel word is taken this cycle.
REQ-007 The block SHALL have port data, output, DATA_W bits: the registered output word.
REQ-008 The block SHALL have port sel, output, 2 bits: the source channel of data (00=A, 01=B, 10=C, 11=D), matching the downstream demux select encoding.
REQ-009 The block SHALL have port out_valid, output, 1 bit: data/sel hold a word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the word.

Function
REQ-011 The block SHALL hold a single output register {out_valid, data, sel} and a 2-bit slot pointer ptr.
REQ-012 load_en SHALL equal (!out_valid || out_ready).
REQ-013 A channel transfer SHALL occur when its x_valid and x_ready are both 1; at most one x_ready SHALL be 1 in any cycle.
REQ-014 x_ready SHALL be combinational: load_en && (grant == x); it SHALL NOT depend on x_valid of other channels except through grant selection (REQ-026).
REQ-015 On a transfer, data SHALL load the granted word and sel the granted index, with out_valid=1 on the next edge (1-cycle latency).
REQ-016 If load_en=1 and no transfer occurs, out_valid SHALL go to 0; data and sel SHALL hold their values.
REQ-017 If load_en=0 (out_valid=1, out_ready=0), data, sel, out_valid and ptr SHALL hold, and all x_ready SHALL be 0.
REQ-018 The word SHALL be simultaneously drained and refilled in the same cycle (out_valid=1, out_ready=1, transfer), sustaining one word per cycle.
REQ-019 ptr SHALL wrap 3 -> 0 with no extra cycle.
REQ-020 Input words whose x_valid stays 1 with x_ready=0 SHALL remain un-consumed; no word is dropped or duplicated.

Reset
REQ-021 Asserting reset SHALL immediately force out_valid=0, data=0, sel=2'b00, ptr=0, regardless of clk.
REQ-022 While reset=1, all x_ready SHALL be 0.
REQ-023 A word held in the output register when reset asserts mid-operation SHALL be discarded.
REQ-024 The first grant after reset deassertion SHALL start from channel A.

Configuration
REQ-025 Without macro TDM_MUX_SKIP_IDLE_EN (strict TDM): grant SHALL equal ptr; ptr SHALL advance by 1 on every cycle with load_en=1 whether or not the slot's channel is valid.
REQ-026 With TDM_MUX_SKIP_IDLE_EN defined (work-conserving round robin): grant SHALL be the first valid channel searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); on a transfer ptr SHALL become grant+1; with no valid channel ptr SHALL hold.

Verification
REQ-027 Reset then all four valid, A..D=11,22,33,44, out_ready=1 -> outputs (data,sel) 11/0, 22/1, 33/2, 44/3, 11/0 ... on consecutive cycles, first out_valid 1 cycle after reset release.
REQ-028 Only C valid (C=5A), out_ready=1 -> strict: 5A/2 every 4th cycle, out_valid=0 between; SKIP_IDLE: 5A/2 every cycle.
REQ-029 All valid, out_ready=0 for 3 cycles after first load -> data/sel held at 11/0, all x_ready=0, then 22/1 follows once out_ready returns to 1.
REQ-030 Async reset pulse between clock edges while out_valid=1 -> out_valid, data, sel clear immediately; next grant is A.
REQ-031 SKIP_IDLE, B and D valid, ptr=0 -> grants alternate B, D, B, D with sel 1,3,1,3.
REQ-032 Every cycle: at most one x_ready=1, and every x_valid&&x_ready word appears exactly once at data with the matching sel.
